// File: rtl/pipeline_hazard_unit.sv
// Pipeline hazard unit: load-use stall, EX operand forwarding, branch flush and halt/drain FSM.
// Optional statistics counters are built only when HAZARD_STATS_EN is defined.
module pipeline_hazard_unit #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned RA_W      = 3,
  parameter int unsigned DRAIN_CYC = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              id_halt,
  input  logic              id_use_ra,
  input  logic              id_use_rb,
  input  logic [RA_W-1:0]   id_ra,
  input  logic [RA_W-1:0]   id_rb,
  input  logic [RA_W-1:0]   id_rd,
  input  logic              br_taken,
  input  logic              resume,
  input  logic [DATA_W-1:0] ex_a_rf,
  input  logic [DATA_W-1:0] ex_b_rf,
  input  logic [DATA_W-1:0] exmem_data,
  input  logic [DATA_W-1:0] memwb_data,
  output logic [DATA_W-1:0] ex_a,
  output logic [DATA_W-1:0] ex_b,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              pc_en,
  output logic              ifid_en,
  output logic              bubble_idex,
  output logic              flush_ifid,
  output logic              halted,
  output logic [15:0]       stall_cnt,
  output logic [15:0]       flush_cnt
);

  typedef enum logic [1:0] {StRun, StDrain, StHalted} state_e;

  localparam int unsigned CntW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [CntW-1:0] DrainLast = CntW'(DRAIN_CYC - 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] drain_cnt_q, drain_cnt_d;

  logic            ex_valid_q, ex_regwrite_q, ex_memread_q;
  logic [RA_W-1:0] ex_ra_q, ex_rb_q, ex_rd_q;
  logic            mem_valid_q, mem_regwrite_q;
  logic [RA_W-1:0] mem_rd_q;
  logic            wb_valid_q, wb_regwrite_q;
  logic [RA_W-1:0] wb_rd_q;

  logic hazard, branch;

  assign hazard = ex_valid_q & ex_memread_q & id_valid &
                  ((id_use_ra & (id_ra == ex_rd_q)) | (id_use_rb & (id_rb == ex_rd_q)));
  assign branch = br_taken & ex_valid_q;

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    bubble_idex = 1'b0;
    flush_ifid  = 1'b0;
    halted      = 1'b0;
    if (reset) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      bubble_idex = 1'b1;
      flush_ifid  = 1'b1;
      state_d     = StRun;
      drain_cnt_d = '0;
    end else begin
      unique case (state_q)
        StRun: begin
          // A resolved branch squashes the younger ID instruction, so it overrides a stall.
          if (branch) begin
            flush_ifid  = 1'b1;
            bubble_idex = 1'b1;
          end else if (hazard) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            bubble_idex = 1'b1;
          end else if (id_valid && id_halt) begin
            state_d     = StDrain;
            drain_cnt_d = '0;
          end
        end
        StDrain: begin
          if (branch) begin
            flush_ifid  = 1'b1;
            bubble_idex = 1'b1;
            state_d     = StRun;
            drain_cnt_d = '0;
          end else begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            bubble_idex = 1'b1;
            if (drain_cnt_q == DrainLast) begin
              state_d     = StHalted;
              drain_cnt_d = '0;
            end else begin
              drain_cnt_d = drain_cnt_q + CntW'(1);
            end
          end
        end
        StHalted: begin
          pc_en       = 1'b0;
          ifid_en     = 1'b0;
          bubble_idex = 1'b1;
          halted      = 1'b1;
          if (resume) state_d = StRun;
        end
        default: state_d = StRun;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StRun;
      drain_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  // Stage metadata; a bubble still loads the ID fields but marks the slot invalid.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid_q  <= 1'b0;
      mem_valid_q <= 1'b0;
      wb_valid_q  <= 1'b0;
    end else begin
      ex_valid_q  <= id_valid & ~bubble_idex;
      mem_valid_q <= ex_valid_q;
      wb_valid_q  <= mem_valid_q;
    end
    ex_regwrite_q  <= id_regwrite;
    ex_memread_q   <= id_memread;
    ex_ra_q        <= id_ra;
    ex_rb_q        <= id_rb;
    ex_rd_q        <= id_rd;
    mem_regwrite_q <= ex_regwrite_q;
    mem_rd_q       <= ex_rd_q;
    wb_regwrite_q  <= mem_regwrite_q;
    wb_rd_q        <= mem_rd_q;
  end

  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (mem_valid_q && mem_regwrite_q && (mem_rd_q == ex_ra_q)) fwd_a = 2'b01;
    else if (wb_valid_q && wb_regwrite_q && (wb_rd_q == ex_ra_q)) fwd_a = 2'b10;
    if (mem_valid_q && mem_regwrite_q && (mem_rd_q == ex_rb_q)) fwd_b = 2'b01;
    else if (wb_valid_q && wb_regwrite_q && (wb_rd_q == ex_rb_q)) fwd_b = 2'b10;
  end

  always_comb begin
    case (fwd_a)
      2'b01:   ex_a = exmem_data;
      2'b10:   ex_a = memwb_data;
      default: ex_a = ex_a_rf;
    endcase
    case (fwd_b)
      2'b01:   ex_b = exmem_data;
      2'b10:   ex_b = memwb_data;
      default: ex_b = ex_b_rf;
    endcase
  end

`ifdef HAZARD_STATS_EN
  logic        stall_ev, flush_ev;
  logic [15:0] stall_cnt_q, flush_cnt_q;

  assign stall_ev = ~reset & (state_q == StRun) & hazard & ~branch;
  assign flush_ev = ~reset & (state_q != StHalted) & branch;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_ev && (stall_cnt_q != 16'hFFFF)) stall_cnt_q <= stall_cnt_q + 16'd1;
      if (flush_ev && (flush_cnt_q != 16'hFFFF)) flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Bench for pipeline_hazard_unit: directed cycles push expected values into a scoreboard that a
// negedge monitor drains and compares against the DUT.
module tb_pipeline_hazard_unit;

  localparam int SPc = 0, SIfid = 1, SBub = 2, SFlush = 3, SHalt = 4;
  localparam int SFwdA = 5, SFwdB = 6, SExA = 7, SExB = 8, SStall = 9, SFcnt = 10;

`ifdef HAZARD_STATS_EN
  localparam bit Stats = 1'b1;
`else
  localparam bit Stats = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid, id_regwrite, id_memread, id_halt, id_use_ra, id_use_rb;
  logic [2:0]  id_ra, id_rb, id_rd;
  logic        br_taken, resume;
  logic [15:0] ex_a_rf, ex_b_rf, exmem_data, memwb_data;
  logic [15:0] ex_a, ex_b;
  logic [1:0]  fwd_a, fwd_b;
  logic        pc_en, ifid_en, bubble_idex, flush_ifid, halted;
  logic [15:0] stall_cnt, flush_cnt;

  pipeline_hazard_unit #(
    .DATA_W   (16),
    .RA_W     (3),
    .DRAIN_CYC(3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .id_valid   (id_valid),
    .id_regwrite(id_regwrite),
    .id_memread (id_memread),
    .id_halt    (id_halt),
    .id_use_ra  (id_use_ra),
    .id_use_rb  (id_use_rb),
    .id_ra      (id_ra),
    .id_rb      (id_rb),
    .id_rd      (id_rd),
    .br_taken   (br_taken),
    .resume     (resume),
    .ex_a_rf    (ex_a_rf),
    .ex_b_rf    (ex_b_rf),
    .exmem_data (exmem_data),
    .memwb_data (memwb_data),
    .ex_a       (ex_a),
    .ex_b       (ex_b),
    .fwd_a      (fwd_a),
    .fwd_b      (fwd_b),
    .pc_en      (pc_en),
    .ifid_en    (ifid_en),
    .bubble_idex(bubble_idex),
    .flush_ifid (flush_ifid),
    .halted     (halted),
    .stall_cnt  (stall_cnt),
    .flush_cnt  (flush_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    int          sel;
    logic [15:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  bit   stim_done = 1'b0;
  bit   final_done = 1'b0;

  function automatic logic [15:0] actual(input int sel);
    case (sel)
      SPc:     return {15'd0, pc_en};
      SIfid:   return {15'd0, ifid_en};
      SBub:    return {15'd0, bubble_idex};
      SFlush:  return {15'd0, flush_ifid};
      SHalt:   return {15'd0, halted};
      SFwdA:   return {14'd0, fwd_a};
      SFwdB:   return {14'd0, fwd_b};
      SExA:    return ex_a;
      SExB:    return ex_b;
      SStall:  return stall_cnt;
      SFcnt:   return flush_cnt;
      default: return 16'hDEAD;
    endcase
  endfunction

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (e.cyc != cyc) begin
        errors++;
        $display("FAIL %s: expectation for cycle %0d reached at cycle %0d", e.name, e.cyc, cyc);
      end else if (actual(e.sel) !== e.exp) begin
        errors++;
        $display("FAIL %s (cycle %0d): got %h, expected %h", e.name, cyc, actual(e.sel), e.exp);
      end
    end
    if (stim_done && !final_done) begin
      checks++;
      if (sb.size() != 0) begin
        errors++;
        $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
      end
      final_done = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_regwrite = 0; id_memread = 0; id_halt = 0;
    id_use_ra = 0; id_use_rb = 0; id_ra = 0; id_rb = 0; id_rd = 0;
    br_taken = 0; resume = 0;
  endtask

  task automatic id_instr(input logic rw, input logic mr, input logic ht, input logic ua,
                          input logic ub, input logic [2:0] ra, input logic [2:0] rb,
                          input logic [2:0] rd);
    id_valid = 1; id_regwrite = rw; id_memread = mr; id_halt = ht;
    id_use_ra = ua; id_use_rb = ub; id_ra = ra; id_rb = rb; id_rd = rd;
  endtask

  task automatic chk(input int sel, input logic [15:0] v, input string name);
    exp_t e;
    e.cyc = cyc; e.sel = sel; e.exp = v; e.name = name;
    sb.push_back(e);
  endtask

  initial begin
    reset = 1; idle();
    ex_a_rf = 16'hAAAA; ex_b_rf = 16'hBBBB; exmem_data = 16'h1234; memwb_data = 16'h5678;
    tick();
    chk(SPc, 0, "reset_pc_en"); chk(SIfid, 0, "reset_ifid_en"); chk(SBub, 1, "reset_bubble");
    chk(SFlush, 1, "reset_flush"); chk(SHalt, 0, "reset_halted");
    tick();
    chk(SStall, 0, "reset_stall_cnt"); chk(SFcnt, 0, "reset_flush_cnt");

    // Load r1 then dependent add: one stall, then MEM/WB forward.
    tick(); reset = 0; id_instr(1, 1, 0, 0, 0, 0, 0, 1);
    chk(SPc, 1, "run_pc_en"); chk(SBub, 0, "run_bubble"); chk(SFlush, 0, "run_flush");
    tick(); id_instr(1, 0, 0, 1, 0, 1, 0, 3);
    chk(SPc, 0, "lu_pc_en"); chk(SIfid, 0, "lu_ifid_en"); chk(SBub, 1, "lu_bubble");
    chk(SFlush, 0, "lu_flush");
    tick();
    chk(SPc, 1, "lu_release_pc_en"); chk(SBub, 0, "lu_release_bubble");
    chk(SStall, Stats ? 16'd1 : 16'd0, "lu_stall_cnt");
    tick(); idle();
    chk(SFwdA, 2, "lu_fwd_a"); chk(SExA, 16'h5678, "lu_ex_a");
    chk(SFwdB, 0, "lu_fwd_b"); chk(SExB, 16'hBBBB, "lu_ex_b");

    // Two writes to r2 in MEM and WB; EX/MEM wins.
    tick(); id_instr(1, 0, 0, 0, 0, 0, 0, 2);
    tick(); id_instr(1, 0, 0, 0, 0, 0, 0, 2);
    tick(); id_instr(0, 0, 0, 0, 1, 5, 2, 4);
    tick(); idle();
    chk(SFwdB, 1, "prio_fwd_b"); chk(SExB, 16'h1234, "prio_ex_b");
    chk(SFwdA, 0, "prio_fwd_a"); chk(SExA, 16'hAAAA, "prio_ex_a");

    // Branch coincident with load-use hazard.
    tick(); id_instr(1, 1, 0, 0, 0, 0, 0, 6);
    tick(); id_instr(1, 0, 0, 1, 0, 6, 0, 7); br_taken = 1;
    chk(SFlush, 1, "brlu_flush"); chk(SPc, 1, "brlu_pc_en"); chk(SBub, 1, "brlu_bubble");
    tick(); idle();
    chk(SPc, 1, "brlu_after_pc_en"); chk(SFlush, 0, "brlu_after_flush");
    chk(SStall, Stats ? 16'd1 : 16'd0, "brlu_stall_cnt");
    chk(SFcnt, Stats ? 16'd1 : 16'd0, "brlu_flush_cnt");

    // Halt, drain 3 cycles, halted, resume.
    tick(); id_instr(0, 0, 1, 0, 0, 0, 0, 0);
    chk(SPc, 1, "halt_id_pc_en"); chk(SHalt, 0, "halt_id_halted");
    tick(); idle(); resume = 1;
    chk(SPc, 0, "drain1_pc_en"); chk(SIfid, 0, "drain1_ifid_en"); chk(SBub, 1, "drain1_bubble");
    chk(SHalt, 0, "drain1_halted");
    tick(); resume = 0;
    chk(SPc, 0, "drain2_pc_en");
    tick();
    chk(SHalt, 0, "drain3_halted"); chk(SBub, 1, "drain3_bubble");
    tick(); resume = 1;
    chk(SHalt, 1, "halted"); chk(SPc, 0, "halted_pc_en"); chk(SBub, 1, "halted_bubble");
    tick(); resume = 0;
    chk(SHalt, 0, "resume_halted"); chk(SPc, 1, "resume_pc_en"); chk(SBub, 0, "resume_bubble");

    // Halt squashed by an older branch during drain.
    tick(); id_instr(0, 0, 1, 0, 0, 0, 0, 0);
    tick(); idle(); br_taken = 1;
    chk(SFlush, 1, "drbr_flush"); chk(SPc, 1, "drbr_pc_en"); chk(SHalt, 0, "drbr_halted");
    tick(); br_taken = 0;
    chk(SPc, 1, "drbr_run_pc_en"); chk(SBub, 0, "drbr_run_bubble");
    chk(SFcnt, Stats ? 16'd2 : 16'd0, "drbr_flush_cnt");
    tick(); tick();
    chk(SHalt, 0, "drbr_never_halted"); chk(SPc, 1, "drbr_late_pc_en");

    // Reset in the middle of drain.
    tick(); id_instr(1, 0, 1, 0, 0, 0, 0, 0);
    tick(); idle();
    chk(SPc, 0, "rstdr_drain_pc_en");
    tick(); reset = 1;
    chk(SFwdA, 1, "rstdr_pre_fwd_a"); chk(SPc, 0, "rstdr_pc_en"); chk(SIfid, 0, "rstdr_ifid_en");
    chk(SBub, 1, "rstdr_bubble"); chk(SFlush, 1, "rstdr_flush"); chk(SHalt, 0, "rstdr_halted");
    tick(); reset = 0;
    chk(SPc, 1, "rstdr_run_pc_en"); chk(SBub, 0, "rstdr_run_bubble");
    chk(SFlush, 0, "rstdr_run_flush"); chk(SHalt, 0, "rstdr_run_halted");
    chk(SFwdA, 0, "rstdr_fwd_a"); chk(SFwdB, 0, "rstdr_fwd_b");
    chk(SStall, 0, "rstdr_stall_cnt"); chk(SFcnt, 0, "rstdr_flush_cnt");
    tick();
    chk(SHalt, 0, "rstdr_no_halt");
    tick();
    chk(SPc, 1, "rstdr_no_stall");

    stim_done = 1'b1;
    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
